// File: rtl/types.sv
// Shared types for the multi-queue transmit arbiter: flit payload, arbitration
// policy selector and the packet-lock FSM states.
package types;

  typedef logic [127:0] flit_t;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_flit_fifo.sv
// Single-clock circular FIFO with a combinational head view, used as the
// per-channel flit queue. Storage has no reset; only pointers and count do.
module param_flit_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_ok};
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/multi_queue_tx_arbiter.sv
// Packet-aware multi-channel transmit arbiter: one flit FIFO per channel,
// fixed or round-robin grant, grant locked until the tail flit leaves.
module multi_queue_tx_arbiter
  import types::*;
#(
  parameter int        NUM_CH   = 3,
  parameter int        DEPTH    = 4,
  parameter int        FLIT_W   = $bits(flit_t),
  parameter arb_mode_t ARB_MODE = ARB_RR,
  localparam int       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int       OCC_W    = $clog2(DEPTH) + 1
) (
  input  logic                             nocclk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0][FLIT_W-1:0]    in_flit,
  input  logic [NUM_CH-1:0]                in_last,
  input  logic [NUM_CH-1:0]                in_valid,
  output logic [NUM_CH-1:0]                in_ready,
  output logic [FLIT_W-1:0]                out_flit,
  output logic                             out_last,
  output logic [CH_W-1:0]                  out_channel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH-1:0][OCC_W-1:0]     occupancy
);

  localparam int EXT_N = 1 << CH_W;

  logic [NUM_CH-1:0][FLIT_W:0] head;
  logic [NUM_CH-1:0]           full, empty, push, pop;
  logic [EXT_N-1:0]            avail_ext;

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] winner, cand;
  logic [CH_W:0]   rr_sum;
  logic [FLIT_W:0] sel_entry;
  logic            do_pop;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign in_ready[gi] = ~full[gi];
    assign push[gi]     = in_valid[gi] & ~full[gi];
    assign pop[gi]      = do_pop & (cand == CH_W'(gi));

    param_flit_fifo #(
      .W     (FLIT_W + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i       (nocclk),
      .rst_ni      (rst_n),
      .push_i      (push[gi]),
      .push_data_i ({in_last[gi], in_flit[gi]}),
      .pop_i       (pop[gi]),
      .head_data_o (head[gi]),
      .count_o     (occupancy[gi]),
      .full_o      (full[gi]),
      .empty_o     (empty[gi])
    );
  end

  // Winner search; loops run downward so the last hit is the preferred channel.
  always_comb begin
    avail_ext               = '0;
    avail_ext[NUM_CH-1:0]   = ~empty;
    rr_sum                  = '0;
    winner                  = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (avail_ext[CH_W'(i)]) winner = CH_W'(i);
      end
    end else begin
      for (int off = NUM_CH - 1; off >= 0; off--) begin
        rr_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
        if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
        if (avail_ext[rr_sum[CH_W-1:0]]) winner = rr_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    cand      = (state_q == HOLD) ? lock_ch_q : winner;
    sel_entry = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand == CH_W'(i)) sel_entry = head[i];
    end
    out_valid   = avail_ext[cand];
    out_channel = cand;
    out_flit    = out_valid ? sel_entry[FLIT_W-1:0] : '0;
    out_last    = out_valid & sel_entry[FLIT_W];
    do_pop      = out_valid & out_ready;
  end

  // Lock on a stalled head or a non-tail pop so the output never reorders
  // mid-stall and packets from different channels never interleave.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if ((do_pop && !out_last) || (out_valid && !out_ready)) begin
          state_d   = HOLD;
          lock_ch_d = cand;
        end
      end
      HOLD: begin
        if (do_pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_pop && out_last) begin
      rr_ptr_d = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_multi_queue_tx_arbiter.sv
// Directed scoreboard bench: dut 0 is round-robin, dut 1 is fixed priority.
module tb_multi_queue_tx_arbiter;

  typedef struct packed {
    logic [1:0]   ch;
    logic [127:0] f;
    logic         l;
  } exp_t;

  logic               nocclk;
  logic               rst_n;
  logic [2:0][127:0]  in_flit_s   [2];
  logic [2:0]         in_last_s   [2];
  logic [2:0]         in_valid_s  [2];
  logic               out_ready_s [2];
  logic [2:0]         in_ready_w  [2];
  logic [127:0]       out_flit_w  [2];
  logic               out_last_w  [2];
  logic [1:0]         out_chan_w  [2];
  logic               out_valid_w [2];
  logic [2:0][2:0]    occ_w       [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   total = 0;
  int   bad   = 0;

  multi_queue_tx_arbiter #(
    .NUM_CH(3), .DEPTH(4), .FLIT_W(128), .ARB_MODE(types::ARB_RR)
  ) dut_rr (
    .nocclk(nocclk), .rst_n(rst_n),
    .in_flit(in_flit_s[0]), .in_last(in_last_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_w[0]), .out_flit(out_flit_w[0]), .out_last(out_last_w[0]),
    .out_channel(out_chan_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready_s[0]), .occupancy(occ_w[0])
  );

  multi_queue_tx_arbiter #(
    .NUM_CH(3), .DEPTH(4), .FLIT_W(128), .ARB_MODE(types::ARB_FIXED)
  ) dut_fx (
    .nocclk(nocclk), .rst_n(rst_n),
    .in_flit(in_flit_s[1]), .in_last(in_last_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_w[1]), .out_flit(out_flit_w[1]), .out_last(out_last_w[1]),
    .out_channel(out_chan_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready_s[1]), .occupancy(occ_w[1])
  );

  initial nocclk = 1'b0;
  always #5 nocclk = ~nocclk;

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_pop(input int d);
    exp_t e;
    total++;
    if (qsize(d) == 0) begin
      bad++;
      $display("FAIL unexpected_out dut%0d actual=ch%0d/%0h required=none",
               d, out_chan_w[d], out_flit_w[d]);
    end else begin
      if (d == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if ({out_chan_w[d], out_flit_w[d], out_last_w[d]} !== e) begin
        bad++;
        $display("FAIL out_flit dut%0d actual=ch%0d/%0h/l%0b required=ch%0d/%0h/l%0b",
                 d, out_chan_w[d], out_flit_w[d], out_last_w[d], e.ch, e.f, e.l);
      end else begin
        $display("pop dut%0d ch%0d flit=%0h last=%0b", d, e.ch, e.f, e.l);
      end
    end
  endtask

  // Monitor: compares every accepted output flit against the scoreboard.
  always @(negedge nocclk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (out_valid_w[d] && out_ready_s[d]) check_pop(d);
      end
    end
  end

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic push(input int d, input int ch, input logic [127:0] f, input logic l);
    in_valid_s[d][ch] = 1'b1;
    in_flit_s[d][ch]  = f;
    in_last_s[d][ch]  = l;
    tick();
    in_valid_s[d][ch] = 1'b0;
  endtask

  task automatic expect_out(input int d, input int ch, input logic [127:0] f, input logic l);
    exp_t e;
    e.ch = 2'(ch);
    e.f  = f;
    e.l  = l;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (qsize(d) != 0) begin
      bad++;
      $display("FAIL drain_dut%0d actual_left=%0d required_left=0", d, qsize(d));
    end
    tick();
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      in_flit_s[d]   = '0;
      in_last_s[d]   = '0;
      in_valid_s[d]  = '0;
      out_ready_s[d] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_in_ready"},  128'(in_ready_w[d]),  128'h7);
      chk({tag, "_out_valid"}, 128'(out_valid_w[d]), 128'h0);
      chk({tag, "_out_flit"},  out_flit_w[d],        128'h0);
      chk({tag, "_out_last"},  128'(out_last_w[d]),  128'h0);
      chk({tag, "_out_chan"},  128'(out_chan_w[d]),  128'h0);
      chk({tag, "_occ"},       128'(occ_w[d]),       128'h0);
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check_idle_outputs("in_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Fill ch0 to DEPTH with the output stalled; the fifth push must be dropped.
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 128'h100 + 128'(i), 1'b1);
      expect_out(0, 0, 128'h100 + 128'(i), 1'b1);
    end
    chk("fill_occ0", 128'(occ_w[0][0]), 128'd4);
    chk("fill_in_ready0", 128'(in_ready_w[0][0]), 128'd0);
    push(0, 0, 128'h1FF, 1'b1);
    chk("fill_5th_ignored", 128'(occ_w[0][0]), 128'd4);
    chk("fill_head", out_flit_w[0], 128'h100);
    out_ready_s[0] = 1'b1;
    drain(0);
    chk("fill_drained_occ", 128'(occ_w[0]), 128'h0);

    // Round-robin between two channels of single-flit packets.
    apply_reset();
    push(0, 0, 128'hB0, 1'b1);
    push(0, 0, 128'hB2, 1'b1);
    push(0, 1, 128'hB1, 1'b1);
    push(0, 1, 128'hB3, 1'b1);
    expect_out(0, 0, 128'hB0, 1'b1);
    expect_out(0, 1, 128'hB1, 1'b1);
    expect_out(0, 0, 128'hB2, 1'b1);
    expect_out(0, 1, 128'hB3, 1'b1);
    out_ready_s[0] = 1'b1;
    drain(0);

    // Packet lock: ch0 arrives while ch1's packet is mid-flight and starved.
    apply_reset();
    out_ready_s[0] = 1'b1;
    expect_out(0, 1, 128'hC1A, 1'b0);
    expect_out(0, 1, 128'hC1B, 1'b0);
    expect_out(0, 1, 128'hC1C, 1'b1);
    expect_out(0, 0, 128'hD0, 1'b1);
    push(0, 1, 128'hC1A, 1'b0);
    push(0, 1, 128'hC1B, 1'b0);
    push(0, 0, 128'hD0, 1'b1);
    chk("lock_hold_valid", 128'(out_valid_w[0]), 128'h0);
    chk("lock_hold_chan", 128'(out_chan_w[0]), 128'h1);
    push(0, 1, 128'hC1C, 1'b1);
    drain(0);

    // Backpressure: stalled ch2 head must not be displaced by ch0 arriving.
    apply_reset();
    push(0, 2, 128'hE0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(out_valid_w[0]), 128'h1);
      chk("bp_chan", 128'(out_chan_w[0]), 128'h2);
      chk("bp_flit", out_flit_w[0], 128'hE0);
      tick();
    end
    push(0, 0, 128'hF0, 1'b1);
    tick();
    chk("bp_after_ch0_chan", 128'(out_chan_w[0]), 128'h2);
    chk("bp_after_ch0_flit", out_flit_w[0], 128'hE0);
    expect_out(0, 2, 128'hE0, 1'b1);
    expect_out(0, 0, 128'hF0, 1'b1);
    out_ready_s[0] = 1'b1;
    drain(0);

    // Reset mid-packet: nothing buffered or held may survive.
    apply_reset();
    push(0, 1, 128'hA0, 1'b0);
    push(0, 1, 128'hA1, 1'b0);
    chk("pre_reset_occ1", 128'(occ_w[0][1]), 128'd2);
    apply_reset();
    chk("post_reset_valid", 128'(out_valid_w[0]), 128'h0);
    chk("post_reset_occ", 128'(occ_w[0]), 128'h0);
    out_ready_s[0] = 1'b1;
    expect_out(0, 0, 128'h900, 1'b1);
    push(0, 0, 128'h900, 1'b1);
    drain(0);

    // Fixed priority: ch0 kept non-empty starves ch2 until ch0 runs dry.
    apply_reset();
    for (int i = 0; i < 8; i++) expect_out(1, 0, 128'h300 + 128'(i), 1'b1);
    expect_out(1, 2, 128'h500, 1'b1);
    expect_out(1, 2, 128'h501, 1'b1);
    for (int i = 0; i < 3; i++) push(1, 0, 128'h300 + 128'(i), 1'b1);
    push(1, 2, 128'h500, 1'b1);
    push(1, 2, 128'h501, 1'b1);
    out_ready_s[1] = 1'b1;
    for (int i = 3; i < 8; i++) push(1, 0, 128'h300 + 128'(i), 1'b1);
    chk("fixed_ch2_waiting", 128'(occ_w[1][2]), 128'd2);
    chk("fixed_chan0", 128'(out_chan_w[1]), 128'h0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_queue_tx_arbiter.md
MULTI_QUEUE_TX_ARBITER -- requirements
Module: multi_queue_tx_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, is the number of input channels; legal range 1..8.
REQ-002 Parameter DEPTH, default 4, is the per-channel FIFO depth in flits; power of two, at least 2.
REQ-003 Parameter FLIT_W, default 128, is the flit width; the default equals the width of types::flit_t.
REQ-004 Parameter ARB_MODE, default types::ARB_RR, selects arbitration: types::ARB_FIXED (lowest index wins) or types::ARB_RR (round-robin).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- nocclk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_flit  in  NUM_CH x FLIT_W  flit for each channel.
- in_last  in  NUM_CH  tail-flit marker for each channel.
- in_valid  in  NUM_CH  push request for each channel.
- in_ready  out  NUM_CH  channel FIFO can accept a flit.
- out_flit  out  FLIT_W  head flit of the granted channel.
- out_last  out  1  tail marker travelling with out_flit.
- out_channel  out  CH_W  index of the granted channel; CH_W = max(1, clog2(NUM_CH)).
- out_valid  out  1  out_flit is valid.
- out_ready  in  1  downstream accepts the flit.
- occupancy  out  NUM_CH x (clog2(DEPTH)+1)  current fill level of each FIFO.

Function
REQ-006 A channel push SHALL occur on a rising edge when in_valid[i] and in_ready[i] are both high; {in_flit, in_last} are stored in FIFO i.
REQ-007 in_ready[i] SHALL be high exactly when occupancy[i] < DEPTH, derived from registered state only; there is no same-cycle bypass when the FIFO is full.
REQ-008 A pop SHALL occur on a rising edge when out_valid and out_ready are both high; it removes the head entry of FIFO out_channel.
REQ-009 Latency: a flit pushed at edge k SHALL be presentable on out_flit no earlier than the cycle following edge k.
REQ-010 Simultaneous push and pop on the same channel SHALL leave occupancy unchanged; read and write pointers each wrap modulo DEPTH.
REQ-011 The FSM SHALL have two states, IDLE and HOLD, plus registered lock_ch and rr_ptr.
REQ-012 In IDLE, the grant SHALL be chosen combinationally among non-empty channels.
- ARB_FIXED: the lowest-index non-empty channel wins.
- ARB_RR: the first non-empty channel searching upward from rr_ptr, wrapping, wins.
REQ-013 In HOLD, the only candidate SHALL be lock_ch; out_valid = (occupancy[lock_ch] != 0).
REQ-014 From IDLE, the FSM SHALL go to HOLD with lock_ch set to the winner when:
- out_valid is high and out_ready is low, or
- a pop occurs with out_last low.
REQ-015 From HOLD, the FSM SHALL return to IDLE only on a pop with out_last high.
REQ-016 Whenever a pop with out_last high completes a packet, rr_ptr SHALL be set to (granted channel + 1) mod NUM_CH; rr_ptr is otherwise unchanged.
REQ-017 While out_valid is high and out_ready is low, out_flit, out_last and out_channel SHALL remain stable.
REQ-018 Flits of different channels SHALL never interleave within a packet on the output.
REQ-019 When out_valid is low, out_flit and out_last SHALL be driven to 0, and out_channel shows the candidate channel.
REQ-020 With NUM_CH=1, the block SHALL behave as a single FIFO with packet-unaware pass-through.

Reset
REQ-021 On rst_n low, the block SHALL asynchronously clear all FIFO pointers and occupancy to 0, set the state to IDLE, and set lock_ch and rr_ptr to 0.
REQ-022 During reset, the outputs SHALL be: in_ready all 1, out_valid 0, out_flit 0, out_last 0, out_channel 0.
REQ-023 Reset asserted in mid-packet SHALL discard all buffered flits and any held grant; nothing is replayed after release.

Structure
REQ-024 The types package SHALL hold flit_t and the enum arb_mode_t {ARB_FIXED, ARB_RR}.
REQ-025 The per-channel storage SHALL be one sub-module, param_flit_fifo (parameters FLIT_W+1, DEPTH), instantiated NUM_CH times by generate.
REQ-026 The arbiter and FSM SHALL reside in the top module.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Fill: push 4 flits into ch0 with DEPTH=4, out_ready=0 -> occupancy[0]=4 and in_ready[0]=0; a 5th push is ignored.
- RR: ch0 and ch1 each hold single-flit packets, out_ready=1 -> outputs alternate ch0, ch1, ch0, ch1.
- Fixed: ARB_FIXED, ch0 and ch2 both always non-empty -> all packets come from ch0; ch2 never granted.
- Packet lock: ch1 3-flit packet (last on the 3rd) with a ch0 flit arriving mid-packet -> ch1 flits 1-3 are contiguous, then ch0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, then a higher-priority channel fills -> out_channel and out_flit are unchanged until the pop.
- Reset: rst_n low after flit 2 of a 3-flit packet -> out_valid=0, all occupancy=0, state IDLE on release.
